// File: rtl/mc_ctrl_pkg.sv
// Shared types for the parametrised multicycle controller: FSM states, IR classes,
// ALU / branch / MISC sub-op encodings and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_FETCH,
    S_DECODE,
    S_FOP,
    S_LDOP,
    S_LDB,
    S_EXEC,
    S_WB,
    S_BR,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    IC_MEM,
    IC_ACC,
    IC_JMP,
    IC_MISC
  } ir_class_t;

  typedef enum logic [1:0] {
    ALU_PASS_B = 2'b00,
    ALU_ADD    = 2'b01,
    ALU_AND    = 2'b10,
    ALU_SUB    = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_C      = 2'b01,
    BR_Z      = 2'b10,
    BR_N      = 2'b11
  } br_cond_t;

  typedef enum logic [1:0] {
    MISC_NOP  = 2'b00,
    MISC_HALT = 2'b01,
    MISC_ILL0 = 2'b10,
    MISC_ILL1 = 2'b11
  } misc_sub_t;

  localparam logic [1:0] CLS_ACC_TAG  = 2'b10;
  localparam logic [2:0] CLS_JMP_TAG  = 3'b110;

  // Classify from the three most significant IR bits.
  function automatic ir_class_t ir_class(input logic [2:0] top);
    if (!top[2])
      return IC_MEM;
    else if (top[2:1] == CLS_ACC_TAG)
      return IC_ACC;
    else if (top == CLS_JMP_TAG)
      return IC_JMP;
    else
      return IC_MISC;
  endfunction

  // czn is {C,Z,N}.
  function automatic logic cond_met(input logic [1:0] cond, input logic [2:0] czn);
    case (cond)
      BR_ALWAYS: return 1'b1;
      BR_C:      return czn[2];
      BR_Z:      return czn[1];
      default:   return czn[0];
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_param_mem_wait_timer.sv
// Counts consecutive memory-read cycles without mem_ready; hit flags the cycle
// on which the wait limit is reached while the read is still unanswered.
module mem_wait_timer #(
  parameter  int WAIT_MAX = 15,
  localparam int CW       = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic hit
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick && (count != CW'(WAIT_MAX)))
      count <= count + 1'b1;
  end

  // count holds the number of earlier unanswered cycles, so this is wait cycle WAIT_MAX.
  assign hit = tick && (count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mc_ctrl_param.sv
// Multicycle controller for an accumulator-file datapath: fetch/decode/operand/
// execute/writeback sequencing with memory wait timeout and HALT/illegal detection.
module mc_ctrl_param
  import mc_ctrl_pkg::*;
#(
  parameter  int IR_W     = 8,
  parameter  int NUM_ACC  = 4,
  parameter  int WAIT_MAX = 15,
  localparam int AI_W     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IR_W-1:0] ir,
  input  logic [2:0]      czn,
  input  logic            mem_ready,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic            mem_rd,
  output logic            addr_sel,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            ir_we,
  output logic            tr_we,
  output logic            a_we,
  output logic            b_we,
  output logic            b_src,
  output logic [AI_W-1:0] acc_rsel,
  output logic [AI_W-1:0] acc_wsel,
  output logic            acc_we,
  output logic            res_we,
  output logic [1:0]      alu_op,
  output logic            flags_we
);

  state_t          state, state_nx;
  ir_class_t       cls;
  logic [1:0]      op;
  logic [AI_W-1:0] dst, src;
  logic [1:0]      cond;
  logic [1:0]      sub;
  logic            wait_hit;

  // IR field extraction; op/dst positions depend on the instruction class.
  always_comb begin
    cls  = ir_class(ir[IR_W-1 -: 3]);
    src  = ir[AI_W-1:0];
    cond = ir[IR_W-4 -: 2];
    sub  = ir[1:0];
    if (cls == IC_MEM) begin
      op  = ir[IR_W-2 -: 2];
      dst = ir[AI_W-1:0];
    end else begin
      op  = ir[IR_W-3 -: 2];
      dst = ir[2*AI_W-1 -: AI_W];
    end
  end

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (!mem_rd || mem_ready),
    .tick  (mem_rd && !mem_ready),
    .hit   (wait_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_ARM;
      S_ARM:    if (!start) state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready)     state_nx = S_DECODE;
        else if (wait_hit) state_nx = S_ERR;
      end
      S_DECODE: begin
        case (cls)
          IC_MEM, IC_JMP: state_nx = S_FOP;
          IC_ACC:         state_nx = S_LDOP;
          default: begin
            case (sub)
              MISC_NOP:  state_nx = S_FETCH;
              MISC_HALT: state_nx = S_IDLE;
              default:   state_nx = S_ERR;
            endcase
          end
        endcase
      end
      S_FOP: begin
        if (mem_ready)     state_nx = (cls == IC_JMP) ? S_BR : S_LDOP;
        else if (wait_hit) state_nx = S_ERR;
      end
      S_LDOP: begin
        if (cls == IC_MEM) begin
          if (mem_ready)     state_nx = S_EXEC;
          else if (wait_hit) state_nx = S_ERR;
        end else begin
          state_nx = S_LDB;
        end
      end
      S_LDB:    state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      S_BR:     state_nx = S_FETCH;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    done     = 1'b0;
    busy     = (state != S_IDLE) && (state != S_ERR);
    err      = 1'b0;
    mem_rd   = 1'b0;
    addr_sel = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_we    = 1'b0;
    tr_we    = 1'b0;
    a_we     = 1'b0;
    b_we     = 1'b0;
    b_src    = 1'b0;
    acc_rsel = '0;
    acc_wsel = '0;
    acc_we   = 1'b0;
    res_we   = 1'b0;
    alu_op   = '0;
    flags_we = 1'b0;
    case (state)
      S_IDLE: done = 1'b1;
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ready;
        pc_inc = mem_ready;
      end
      S_FOP: begin
        mem_rd = 1'b1;
        tr_we  = mem_ready;
        pc_inc = mem_ready;
      end
      S_LDOP: begin
        acc_rsel = dst;
        // MEM-ALU loads A and B together once the operand word arrives.
        if (cls == IC_MEM) begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
          b_src    = 1'b1;
          a_we     = mem_ready;
          b_we     = mem_ready;
        end else begin
          a_we = 1'b1;
        end
      end
      S_LDB: begin
        acc_rsel = src;
        b_we     = 1'b1;
      end
      S_EXEC: begin
        res_we   = 1'b1;
        alu_op   = op;
        flags_we = (op != ALU_PASS_B);
      end
      S_WB: begin
        acc_we   = 1'b1;
        acc_wsel = dst;
      end
      S_BR:  pc_ld = cond_met(cond, czn);
      S_ERR: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_param.sv
// Randomised scoreboard bench for mc_ctrl_param: a program-level model predicts each
// strobe cycle (with cycle stamp) and a monitor compares every strobe the controller emits.
module tb_mc_ctrl_param;

  localparam int IR_W     = 8;
  localparam int NUM_ACC  = 4;
  localparam int WAIT_MAX = 15;
  localparam int AI_W     = 2;
  localparam logic [31:0] IDLE_V = 32'h0010_0000;
  localparam logic [31:0] ERR_V  = 32'h0004_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [IR_W-1:0] ir = '0;
  logic [2:0]      czn = '0;
  logic            mem_ready = 1'b0;
  logic            done, busy, err, mem_rd, addr_sel, pc_inc, pc_ld, ir_we, tr_we;
  logic            a_we, b_we, b_src, acc_we, res_we, flags_we;
  logic [AI_W-1:0] acc_rsel, acc_wsel;
  logic [1:0]      alu_op;

  mc_ctrl_param #(
    .IR_W     (IR_W),
    .NUM_ACC  (NUM_ACC),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ir        (ir),
    .czn       (czn),
    .mem_ready (mem_ready),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .mem_rd    (mem_rd),
    .addr_sel  (addr_sel),
    .pc_inc    (pc_inc),
    .pc_ld     (pc_ld),
    .ir_we     (ir_we),
    .tr_we     (tr_we),
    .a_we      (a_we),
    .b_we      (b_we),
    .b_src     (b_src),
    .acc_rsel  (acc_rsel),
    .acc_wsel  (acc_wsel),
    .acc_we    (acc_we),
    .res_we    (res_we),
    .alu_op    (alu_op),
    .flags_we  (flags_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic mem_rd, addr_sel, ir_we, tr_we, pc_inc, pc_ld, a_we, b_we, b_src;
    logic [1:0] acc_rsel, acc_wsel;
    logic acc_we, res_we;
    logic [1:0] alu_op;
    logic flags_we;
  } ev_t;

  ev_t        exp_q[$];
  int         delay_q[$];
  logic [7:0] prog_q[$];
  logic [7:0] code[$];
  int         checks = 0;
  int         errors = 0;
  bit         rd_active = 1'b0;
  int         rd_left = 0;

  function automatic logic [31:0] outs();
    return 32'({done, busy, err, mem_rd, addr_sel, pc_inc, pc_ld, ir_we, tr_we, a_we, b_we,
                b_src, acc_rsel, acc_wsel, acc_we, res_we, alu_op, flags_we});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic ev_t ev_at(input int c);
    ev_t e;
    e = '0;
    e.cyc = 32'(c);
    return e;
  endfunction

  // mode >= 0: fixed wait; -1: random 0..3; -2: random with occasional timeout.
  function automatic int pick(input int mode);
    if (mode >= 0) return mode;
    if (mode == -2 && $urandom_range(0, 15) == 0) return WAIT_MAX;
    return $urandom_range(0, 3);
  endfunction

  function automatic logic taken(input logic [1:0] c, input logic [2:0] f);
    case (c)
      2'd0:    return 1'b1;
      2'd1:    return f[2];
      2'd2:    return f[1];
      default: return f[0];
    endcase
  endfunction

  // Program-level model: walks the instruction list, assigning each expected strobe a cycle.
  task automatic model_prog(input int t0, input int mode, output int end_cyc, output bit end_err);
    int t, d, dc, l;
    bit fin;
    ev_t e;
    logic [7:0] w;
    t = t0; fin = 0; end_err = 0; end_cyc = 0;
    for (int i = 0; i < code.size() && !fin; i++) begin
      w = code[i];
      d = pick(mode); delay_q.push_back(d);
      if (d >= WAIT_MAX) begin
        end_cyc = t + WAIT_MAX; end_err = 1; fin = 1;
      end else begin
        e = ev_at(t + d); e.mem_rd = 1; e.ir_we = 1; e.pc_inc = 1; exp_q.push_back(e);
        prog_q.push_back(w);
        dc = t + d + 1;
        if (!w[7]) begin
          d = pick(mode); delay_q.push_back(d);
          if (d >= WAIT_MAX) begin
            end_cyc = dc + 1 + WAIT_MAX; end_err = 1; fin = 1;
          end else begin
            e = ev_at(dc + 1 + d); e.mem_rd = 1; e.tr_we = 1; e.pc_inc = 1; exp_q.push_back(e);
            l = dc + 2 + d;
            d = pick(mode); delay_q.push_back(d);
            if (d >= WAIT_MAX) begin
              end_cyc = l + WAIT_MAX; end_err = 1; fin = 1;
            end else begin
              e = ev_at(l + d); e.mem_rd = 1; e.addr_sel = 1; e.b_src = 1; e.a_we = 1; e.b_we = 1;
              e.acc_rsel = w[1:0]; exp_q.push_back(e);
              e = ev_at(l + d + 1); e.res_we = 1; e.alu_op = w[6:5]; e.flags_we = (w[6:5] != 2'b00);
              exp_q.push_back(e);
              e = ev_at(l + d + 2); e.acc_we = 1; e.acc_wsel = w[1:0]; exp_q.push_back(e);
              t = l + d + 3;
            end
          end
        end else if (!w[6]) begin
          e = ev_at(dc + 1); e.a_we = 1; e.acc_rsel = w[3:2]; exp_q.push_back(e);
          e = ev_at(dc + 2); e.b_we = 1; e.acc_rsel = w[1:0]; exp_q.push_back(e);
          e = ev_at(dc + 3); e.res_we = 1; e.alu_op = w[5:4]; e.flags_we = (w[5:4] != 2'b00);
          exp_q.push_back(e);
          e = ev_at(dc + 4); e.acc_we = 1; e.acc_wsel = w[3:2]; exp_q.push_back(e);
          t = dc + 5;
        end else if (!w[5]) begin
          d = pick(mode); delay_q.push_back(d);
          if (d >= WAIT_MAX) begin
            end_cyc = dc + 1 + WAIT_MAX; end_err = 1; fin = 1;
          end else begin
            e = ev_at(dc + 1 + d); e.mem_rd = 1; e.tr_we = 1; e.pc_inc = 1; exp_q.push_back(e);
            if (taken(w[4:3], czn)) begin
              e = ev_at(dc + 2 + d); e.pc_ld = 1; exp_q.push_back(e);
            end
            t = dc + 3 + d;
          end
        end else begin
          case (w[1:0])
            2'b00:   t = dc + 1;
            2'b01:   begin end_cyc = dc + 1; fin = 1; end
            default: begin end_cyc = dc + 1; end_err = 1; fin = 1; end
          endcase
        end
      end
    end
    if (!fin) end_cyc = t;
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] w;
    w = 8'($urandom);
    case ($urandom_range(0, 3))
      0:       w[7] = 1'b0;
      1:       w[7:6] = 2'b10;
      2:       w[7:5] = 3'b110;
      default: begin w[7:5] = 3'b111; w[1:0] = 2'b00; end
    endcase
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    exp_q.delete(); delay_q.delete(); prog_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_prog(input int mode, input string name);
    int t0, end_cyc;
    bit end_err;
    @(posedge clk); #1;
    chk({name, "_idle"}, outs(), IDLE_V);
    t0 = cyc + 2;
    model_prog(t0, mode, end_cyc, end_err);
    start = 1'b1;
    @(posedge clk); #1;
    chk({name, "_arm"}, 32'({done, busy, err}), 32'h2);
    start = 1'b0;
    while (cyc < end_cyc) begin
      @(posedge clk); #1;
    end
    chk({name, "_end"}, outs(), end_err ? ERR_V : IDLE_V);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'h0);
    if (end_err) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      chk({name, "_sticky"}, outs(), ERR_V);
      do_reset();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    fork
      // Scoreboard monitor: every strobe cycle must match the next predicted event.
      forever begin
        ev_t a, e;
        @(negedge clk);
        if (!rst && (ir_we || tr_we || pc_inc || pc_ld || a_we || b_we || res_we || acc_we || flags_we)) begin
          a = '0;
          a.cyc = 32'(cyc); a.mem_rd = mem_rd; a.addr_sel = addr_sel; a.ir_we = ir_we;
          a.tr_we = tr_we; a.pc_inc = pc_inc; a.pc_ld = pc_ld; a.a_we = a_we; a.b_we = b_we;
          a.b_src = b_src; a.acc_rsel = acc_rsel; a.acc_wsel = acc_wsel; a.acc_we = acc_we;
          a.res_we = res_we; a.alu_op = alu_op; a.flags_we = flags_we;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d act=%h exp=none", cyc, a);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              errors++;
              $display("FAIL event cyc=%0d act=%h exp=%h", cyc, a, e);
            end
          end
        end
      end
      // Instruction memory image: IR takes the next program word when the controller loads it.
      forever begin
        @(negedge clk);
        if (!rst && ir_we && prog_q.size() > 0) ir = prog_q.pop_front();
      end
      // Memory responder: per-read wait counts from delay_q; random noise when not reading.
      forever begin
        @(posedge clk); #2;
        if (rst) begin
          rd_active = 1'b0;
          mem_ready = 1'b0;
        end else if (mem_rd) begin
          if (!rd_active) begin
            rd_active = 1'b1;
            rd_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
          end
          if (rd_left == 0) begin
            mem_ready = 1'b1;
            rd_active = 1'b0;
          end else begin
            mem_ready = 1'b0;
            rd_left--;
          end
        end else begin
          rd_active = 1'b0;
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none

    do_reset();
    chk("reset_outputs", outs(), IDLE_V);

    czn = 3'b000; code = '{8'h99, 8'hE1}; run_prog(0, "acc_add");
    code = '{8'h63, 8'hE1}; run_prog(3, "mem_sub");
    czn = 3'b010; code = '{8'hD0, 8'hE1}; run_prog(0, "jmp_z_taken");
    czn = 3'b000; code = '{8'hD0, 8'hE1}; run_prog(1, "jmp_z_not");
    czn = 3'b000; code = '{8'hC0, 8'hE1}; run_prog(0, "jmp_always");
    czn = 3'b101; code = '{8'hC8, 8'hD8, 8'hE1}; run_prog(0, "jmp_c_n");
    code = '{8'hE0}; run_prog(WAIT_MAX, "fetch_timeout");
    code = '{8'hE0, 8'hE1}; run_prog(WAIT_MAX - 1, "ready_at_limit");
    code = '{8'hE2}; run_prog(0, "illegal_e2");
    code = '{8'hE3}; run_prog(2, "illegal_e3");
    code = '{8'h00, 8'h81, 8'hE0, 8'hE1}; run_prog(1, "mixed");

    // Reset while the ALU result is being captured: write-back must never happen.
    code = '{8'h99};
    @(posedge clk); #1;
    begin
      int ec;
      bit ee;
      model_prog(cyc + 2, 0, ec, ee);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (res_we) found = 1'b1;
    end
    chk("rst_exec_reached", 32'(found), 32'h1);
    #1 rst = 1'b1;
    #1 chk("rst_async_idle", outs(), IDLE_V);
    chk("rst_wb_pending", 32'(exp_q.size()), 32'h1);
    exp_q.delete(); delay_q.delete(); prog_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("rst_exec_idle", outs(), IDLE_V);

    for (int p = 0; p < 30; p++) begin
      int n;
      code.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) code.push_back(rand_instr());
      code.push_back(8'hE1);
      czn = 3'($urandom);
      run_prog((p % 2 == 1) ? -2 : -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
